mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares a single unified word-addressed memory between instruction fetch (IF) and data memory (DM) requesters.
//  Sequences each access through a fixed-latency memory: issue, wait, capture, acknowledge.
//  DM has priority; a starvation guard forces an IF grant after STARVE_MAX consecutive DM grants.
//  Sits between the PC/fetch stage, the load/store stage and the memory array; the pipeline stalls while ack is low.
// PARAMETERS
//  ADDR_W     30  word-address width (byte address [31:2])
//  DATA_W     32  data width
//  MEM_LAT    2   cycles from the issue cycle to the cycle in which mem_rdata is valid; legal range >= 1
//  STARVE_MAX 4   consecutive DM grants, with IF waiting, after which IF must win; legal range >= 1
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  if_req     in   1       IF read request; held high until if_ack
//  if_addr    in   ADDR_W  IF word address
//  if_ack     out  1       one-cycle pulse: if_rdata is valid
//  if_rdata   out  DATA_W  registered IF read data
//  dm_req     in   1       DM request; held high until dm_ack
//  dm_we      in   1       1 = write, 0 = read
//  dm_addr    in   ADDR_W  DM word address
//  dm_wdata   in   DATA_W  DM write data
//  dm_ack     out  1       one-cycle pulse: DM access is complete and dm_rdata is valid for reads
//  dm_rdata   out  DATA_W  registered DM read data
//  mem_en     out  1       memory access strobe, exactly one cycle per transaction
//  mem_we     out  1       memory write enable; asserted only together with mem_en
//  mem_addr   out  ADDR_W  memory word address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; latched address/data/owner, wait counter and starve counter = 0.
//  Reset during a transaction drops it: no ack is issued. A write already strobed may have completed in memory.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: no request -> stay in IDLE. Any request -> latch owner, addr, we, wdata; go to ISSUE.
//    Owner rule: DM only -> DM. IF only -> IF.
//    Both requesting -> DM, unless starve_cnt == STARVE_MAX, in which case IF wins.
//  starve_cnt: +1 on each DM grant made while if_req=1, saturating at STARVE_MAX; cleared on each IF grant.
//  ISSUE (1 cycle): mem_en=1; mem_we = latched we (always 0 for IF); go to WAIT with wait counter = 1.
//  mem_addr and mem_wdata are driven from latched registers in every non-IDLE state.
//  mem_addr and mem_wdata keep their last values in IDLE.
//  WAIT: on the cycle with wait counter == MEM_LAT, sample mem_rdata into the owner's rdata register
//    (reads only; writes leave dm_rdata unchanged) and go to RESP. Otherwise increment the counter.
//  RESP (1 cycle): owner's ack=1; the other ack stays 0; go to IDLE.
//  Requesters deassert or renew req on the edge that ends RESP. The next arbitration happens in the IDLE cycle.
//  Latency: the request is seen in IDLE cycle T; ack is asserted in cycle T+MEM_LAT+2.
//  Back-to-back throughput: one transaction per MEM_LAT+3 cycles.
//  Requests arriving during non-IDLE states wait. Input changes after latching have no effect on the transaction in flight.
//  if_rdata and dm_rdata hold their values until overwritten by a later read for the same owner.
//  Acks are never both high. mem_en is never high outside ISSUE.
// TESTING
//  1. Single IF read, MEM_LAT=2, addr 0x10, memory returns 0x2402000A -> mem_en at T+1; if_ack at T+4; if_rdata=0x2402000A.
//  2. DM write, addr 0x20, data 0xDEADBEEF -> mem_en=mem_we=1 for exactly 1 cycle; dm_ack at T+4; dm_rdata unchanged.
//  3. IF and DM requesting in the same cycle, starve_cnt=0 -> DM is served first; IF is acked MEM_LAT+3 cycles after dm_ack.
//  4. if_req held while DM issues 6 back-to-back reads, STARVE_MAX=4 -> four DM grants, then IF is granted, then DM resumes.
//  5. reset asserted in WAIT -> all outputs 0 immediately; no ack follows; a new request after release completes normally.
//  6. MEM_LAT=1 build, with random IF/DM traffic against a reference memory -> data matches, no double acks.
//     mem_en pulses equal the ack count.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/DM arbiter in front of a fixed-latency unified word memory
//
// Purpose: grants the single memory port to either the instruction-fetch (IF)
// or the data-memory (DM) requester and sequences each access through
// IDLE -> ISSUE -> WAIT -> RESP. DM wins ties, except that after STARVE_MAX
// consecutive DM grants taken while IF was waiting, IF is granted next.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   if_req/if_addr                  IF read request and word address
//   if_ack/if_rdata                 IF completion pulse and registered read data
//   dm_req/dm_we/dm_addr/dm_wdata   DM request, direction, address, write data
//   dm_ack/dm_rdata                 DM completion pulse and registered read data
//   mem_en/mem_we/mem_addr/mem_wdata  one-cycle memory strobe plus latched command
//   mem_rdata                       memory data, valid MEM_LAT cycles after mem_en
//   busy                            high whenever a transaction is in flight

module mem_arbiter #(
   parameter int ADDR_W     = 30,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int WCNT_W = $clog2(MEM_LAT + 1);
   localparam int SCNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_LAT);
   localparam logic [SCNT_W-1:0] SCNT_TOP  = SCNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                owner_dm_q, owner_dm_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic [SCNT_W-1:0]   starve_q, starve_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic                if_ack_q, if_ack_d;
   logic                dm_ack_q, dm_ack_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
   logic                busy_q, busy_d;
   logic                grant_if;

   always_comb begin
      state_d    = state_q;
      owner_dm_d = owner_dm_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wcnt_d     = wcnt_q;
      starve_d   = starve_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      // IF wins when it is the only requester, or when DM has starved it long enough
      grant_if   = if_req && (!dm_req || (starve_q == SCNT_TOP));

      case (state_q)
         S_IDLE: begin
            if (if_req || dm_req) begin
               owner_dm_d = !grant_if;
               we_d       = !grant_if && dm_we;
               addr_d     = grant_if ? if_addr : dm_addr;
               wdata_d    = dm_wdata;
               if (grant_if) begin
                  starve_d = '0;
               end else if (if_req && (starve_q != SCNT_TOP)) begin
                  starve_d = starve_q + 1'b1;
               end
               // strobe is registered so it lines up with the ISSUE cycle
               mem_en_d = 1'b1;
               mem_we_d = !grant_if && dm_we;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wcnt_d  = WCNT_W'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wcnt_q == WCNT_LAST) begin
               if (!we_q) begin
                  if (owner_dm_q) begin
                     dm_rdata_d = mem_rdata;
                  end else begin
                     if_rdata_d = mem_rdata;
                  end
               end
               // ack is registered so it appears during RESP
               if_ack_d = !owner_dm_q;
               dm_ack_d = owner_dm_q;
               state_d  = S_RESP;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         owner_dm_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wcnt_q     <= '0;
         starve_q   <= '0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_dm_q <= owner_dm_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wcnt_q     <= wcnt_d;
         starve_q   <= starve_d;
         mem_en_q   <= mem_en_d;
         mem_we_q   <= mem_we_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         busy_q     <= busy_d;
      end
   end

   // latched command registers drive the memory bus and hold it through IDLE
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign busy      = busy_q;

endmodule
